brick_game_ctrl: RTL
====================

# brick_game_ctrl

- Game-sequencing controller for the VGA breakout datapath.
- Generates a once-per-frame update strobe from the VGA scan position.
- Moves the board (paddle) from push-buttons, and spawns, drops and resolves one brick per round (catch or miss).
- Keeps score and lives, and drives `board_x/board_y`, `brick_x/brick_y` and a brick-enable to the pixel generator.

## Interface
Parameters:
- `BOARD_WIDTH`, 64, paddle width (px)
- `BOARD_HEIGHT`, 8, paddle height (px)
- `BOARD_Y`, 440, fixed paddle top row
- `BRICK_SIZE`, 50, brick side (px)
- `BOARD_STEP`, 4, paddle px per frame
- `FALL_STEP`, 2, brick px per frame
- `SPAWN_FRAMES`, 30, frames brick is hidden before falling
- `LIVES_INIT`, 3, lives at start (1..3)

Ports:
- `clk`  in  1  100 MHz system clock; the only clock
- `reset`  in  1  synchronous, active-low reset
- `x`, `y`  in  10 each  VGA scan position from the VGA controller
- `btn_l`, `btn_r`, `btn_start`  in  1 each  raw buttons, asynchronous
- `board_x`, `board_y`  out  10 each  paddle top-left
- `brick_x`, `brick_y`  out  10 each  brick top-left
- `brick_en`  out  1  brick is to be drawn
- `score`  out  8  bricks caught, saturating at 255
- `lives`  out  2  remaining lives
- `game_over`  out  1  high in OVER

## Operation
Frame strobe:
- `tick_raw = (y==481 && x==0)`; `tick_d` is a 1-flop register of `tick_raw`.
- `frame_tick = tick_raw & ~tick_d`, giving exactly one cycle per frame even though the pixel is held for 4 clk.

Button synchronisation and LFSR:
- Each button passes through a 2-flop synchroniser. Only synchronised values are used, and only when `frame_tick`=1.
- A 10-bit Fibonacci LFSR with taps 10,7 and seed 10'h1AB is clocked every cycle.
- Spawn x = `lfsr > 590 ? lfsr-512 : lfsr`, so it always lies in 0..590.

Paddle (every `frame_tick`, in all states except OVER):
- `btn_l` only: `board_x` = (`board_x < BOARD_STEP`) ? 0 : `board_x-BOARD_STEP`.
- `btn_r` only: `board_x` = min(`board_x+BOARD_STEP`, 640-`BOARD_WIDTH`).
- Both buttons or neither: hold.
- `board_y` is constant at `BOARD_Y`.

FSM (every transition occurs only on `frame_tick`):
- IDLE: `brick_en`=0. Start → SPAWN, with `score`=0 and `lives`=`LIVES_INIT`.
- SPAWN:
  - On entry: load `brick_x` with the spawn x, `brick_y`=0, `brick_en`=0, frame counter=0.
  - Each tick the counter increments.
  - On the tick where counter==`SPAWN_FRAMES`-1 → FALL, `brick_en`=1.
- FALL:
  - Each tick, decide first: if `brick_y+BRICK_SIZE-1 >= BOARD_Y`, resolve the round.
  - Otherwise `brick_y += FALL_STEP`.
  - Catch condition: `brick_x <= board_x+BOARD_WIDTH-1` and `board_x <= brick_x+BRICK_SIZE-1`. It uses the current registered positions, i.e. pre-update paddle.
  - Catch → `score`+1 (saturating) → SPAWN.
  - Miss → `lives`-1; if `lives` was 1 → OVER, else → SPAWN.
- OVER:
  - `game_over`=1, `brick_en`=0, `brick_x/y` hold, paddle frozen.
  - Start → SPAWN, with `score`=0, `lives`=`LIVES_INIT`, `game_over`=0.
- Start in SPAWN or FALL is ignored.

Reset values: state IDLE; `board_x`=288, `board_y`=`BOARD_Y`, `brick_x`=0, `brick_y`=0, `brick_en`=0, `score`=0, `lives`=`LIVES_INIT`, `game_over`=0, LFSR=10'h1AB, `tick_d`=0, synchroniser flops=0.

## Timing
- All outputs are registered. They update on the `clk` edge where `frame_tick`=1 and are visible the following cycle.
- Raw button to usable: 2 cycles of synchroniser latency, then the next `frame_tick`.
- With the defaults, FALL decides at the tick where `brick_y`=392. That is 196 increment ticks after FALL entry, and the decision is tick 197.
- `reset`=0 at any edge overrides everything, including a coincident `frame_tick`. Reset in mid-FALL yields the reset values next cycle.
- `frame_tick` needs `tick_raw` to deassert before it can fire again. `x,y` stuck at 0/481 produce one tick only.

## Test plan
- Reset held low 2 cycles with buttons active → `board_x`=288, `board_y`=440, `lives`=3, `score`=0, `brick_en`=0, `game_over`=0.
- `x=0,y=481` held 4 clk with `btn_r` → `board_x` 288→292 exactly once. `btn_l` for 80 frames → reaches 0 at frame 72 and holds. `btn_r` for 150 frames → 576, holds. Both buttons → no change.
- Start at a tick → SPAWN. `brick_en` rises after 30 ticks with `brick_x` ≤ 590 and `brick_y`=0. `brick_y` steps 0,2,4…
- Paddle parked so `board_x`=`brick_x` → at decision tick 197 of FALL, `score`=1, state SPAWN, `brick_en`=0. Repeat with `score` preloaded at 255 by 255 catches → `score` stays 255.
- Paddle parked far away, 3 consecutive misses → `lives` 3→2→1→0, `game_over`=1, paddle frozen under `btn_l`. Start → `lives`=3, `score`=0, SPAWN.
- `reset` low mid-FALL (`brick_y`=100) coincident with `frame_tick` → all reset values next cycle, no score/lives change.

Source files
------------

// File: rtl/brick_game_ctrl.sv
// ---------------------------------------------------------------------------
// brick_game_ctrl
//   Game-sequencing controller for the VGA breakout datapath. Derives a
//   once-per-frame update strobe from the VGA scan position, moves the paddle
//   from push-buttons, and spawns, drops and resolves one brick per round.
//   It also keeps the score and the lives count.
//
// Ports
//   clk        in   1   system clock (only clock)
//   reset      in   1   synchronous, active-low reset
//   x, y       in  10   VGA scan position
//   btn_l      in   1   raw left button (asynchronous)
//   btn_r      in   1   raw right button (asynchronous)
//   btn_start  in   1   raw start button (asynchronous)
//   board_x    out 10   paddle top-left column
//   board_y    out 10   paddle top-left row (constant)
//   brick_x    out 10   brick top-left column
//   brick_y    out 10   brick top-left row
//   brick_en   out  1   brick is to be drawn
//   score      out  8   bricks caught, saturating at 255
//   lives      out  2   remaining lives
//   game_over  out  1   high while the game is over
// ---------------------------------------------------------------------------
module brick_game_ctrl #(
    parameter int BOARD_WIDTH  = 64,
    parameter int BOARD_HEIGHT = 8,
    parameter int BOARD_Y      = 440,
    parameter int BRICK_SIZE   = 50,
    parameter int BOARD_STEP   = 4,
    parameter int FALL_STEP    = 2,
    parameter int SPAWN_FRAMES = 30,
    parameter int LIVES_INIT   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_start,
    output logic [9:0] board_x,
    output logic [9:0] board_y,
    output logic [9:0] brick_x,
    output logic [9:0] brick_y,
    output logic       brick_en,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic [9:0] BOARD_MAX   = 10'(640 - BOARD_WIDTH);
    localparam logic [9:0] BOARD_X_RST = 10'd288;
    localparam int         CNT_W       = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPAWN = 2'd1,
        FALL  = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Paddle height only matters to the pixel generator.
    logic [9:0] unused_board_height;
    assign unused_board_height = 10'(BOARD_HEIGHT);

    // ---------------- saturation / clamping helpers ----------------
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    function automatic logic [9:0] move_left(input logic [9:0] pos);
        return (pos < 10'(BOARD_STEP)) ? 10'd0 : pos - 10'(BOARD_STEP);
    endfunction

    function automatic logic [9:0] move_right(input logic [9:0] pos);
        logic [10:0] sum;
        sum = {1'b0, pos} + 11'(BOARD_STEP);
        return (sum > {1'b0, BOARD_MAX}) ? BOARD_MAX : sum[9:0];
    endfunction

    // ---------------- stage p0/p1: button synchronisers, frame strobe ----------------
    logic btn_l_p0, btn_l_p1;
    logic btn_r_p0, btn_r_p1;
    logic btn_s_p0, btn_s_p1;
    logic tick_raw, tick_d, frame_tick;
    logic [9:0] lfsr;
    logic [9:0] spawn_x;

    // The VGA pixel is held for several clocks; the edge detect keeps one
    // strobe per frame.
    assign tick_raw   = (y == 10'd481) && (x == 10'd0);
    assign frame_tick = tick_raw & ~tick_d;

    // Folding values above 590 down by 512 keeps the whole brick on screen.
    assign spawn_x = (lfsr > 10'd590) ? lfsr - 10'd512 : lfsr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_l_p0 <= 1'b0;
            btn_l_p1 <= 1'b0;
            btn_r_p0 <= 1'b0;
            btn_r_p1 <= 1'b0;
            btn_s_p0 <= 1'b0;
            btn_s_p1 <= 1'b0;
            tick_d   <= 1'b0;
            lfsr     <= 10'h1AB;
        end else begin
            btn_l_p0 <= btn_l;
            btn_l_p1 <= btn_l_p0;
            btn_r_p0 <= btn_r;
            btn_r_p1 <= btn_r_p0;
            btn_s_p0 <= btn_start;
            btn_s_p1 <= btn_s_p0;
            tick_d   <= tick_raw;
            lfsr     <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        end
    end

    // ---------------- game state: next-state logic ----------------
    state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [9:0] board_x_nxt, brick_x_nxt, brick_y_nxt;
    logic       brick_en_nxt, game_over_nxt;
    logic [7:0] score_nxt;
    logic [1:0] lives_nxt;
    logic       load_spawn;
    logic [10:0] brick_bottom, board_right, brick_right;
    logic       catch_hit;

    assign brick_bottom = {1'b0, brick_y} + 11'(BRICK_SIZE - 1);
    assign board_right  = {1'b0, board_x} + 11'(BOARD_WIDTH - 1);
    assign brick_right  = {1'b0, brick_x} + 11'(BRICK_SIZE - 1);
    // Horizontal overlap against the paddle position before this frame's move.
    assign catch_hit    = ({1'b0, brick_x} <= board_right) && ({1'b0, board_x} <= brick_right);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        board_x_nxt   = board_x;
        brick_x_nxt   = brick_x;
        brick_y_nxt   = brick_y;
        brick_en_nxt  = brick_en;
        score_nxt     = score;
        lives_nxt     = lives;
        game_over_nxt = game_over;
        load_spawn    = 1'b0;

        if (frame_tick) begin
            if (state != OVER) begin
                if (btn_l_p1 && !btn_r_p1) begin
                    board_x_nxt = move_left(board_x);
                end else if (btn_r_p1 && !btn_l_p1) begin
                    board_x_nxt = move_right(board_x);
                end
            end

            case (state)
                IDLE: begin
                    brick_en_nxt = 1'b0;
                    if (btn_s_p1) begin
                        score_nxt  = 8'd0;
                        lives_nxt  = 2'(LIVES_INIT);
                        load_spawn = 1'b1;
                    end
                end
                SPAWN: begin
                    if (cnt == CNT_W'(SPAWN_FRAMES - 1)) begin
                        state_nxt    = FALL;
                        brick_en_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                FALL: begin
                    // Resolve before moving: the brick never passes the paddle row.
                    if (brick_bottom >= 11'(BOARD_Y)) begin
                        if (catch_hit) begin
                            score_nxt  = sat_inc(score);
                            load_spawn = 1'b1;
                        end else begin
                            lives_nxt = lives - 2'd1;
                            if (lives == 2'd1) begin
                                state_nxt     = OVER;
                                game_over_nxt = 1'b1;
                                brick_en_nxt  = 1'b0;
                            end else begin
                                load_spawn = 1'b1;
                            end
                        end
                    end else begin
                        brick_y_nxt = brick_y + 10'(FALL_STEP);
                    end
                end
                OVER: begin
                    if (btn_s_p1) begin
                        score_nxt     = 8'd0;
                        lives_nxt     = 2'(LIVES_INIT);
                        game_over_nxt = 1'b0;
                        load_spawn    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (load_spawn) begin
                state_nxt    = SPAWN;
                brick_x_nxt  = spawn_x;
                brick_y_nxt  = 10'd0;
                brick_en_nxt = 1'b0;
                cnt_nxt      = '0;
            end
        end
    end

    // ---------------- game state: registers ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            board_x   <= BOARD_X_RST;
            brick_x   <= 10'd0;
            brick_y   <= 10'd0;
            brick_en  <= 1'b0;
            score     <= 8'd0;
            lives     <= 2'(LIVES_INIT);
            game_over <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            board_x   <= board_x_nxt;
            brick_x   <= brick_x_nxt;
            brick_y   <= brick_y_nxt;
            brick_en  <= brick_en_nxt;
            score     <= score_nxt;
            lives     <= lives_nxt;
            game_over <= game_over_nxt;
        end
    end

    assign board_y = 10'(BOARD_Y);

endmodule
